matrix_loader: RTL

Parametrised successor to the single-byte broadcast matrix driver. It accepts byte writes from the Raspberry Pi parallel bus (RPI_IO, write_strobe, cmd_sel), which are asynchronous to clk_100mhz, and synchronises them. Data goes into a shadow bank of NUM_BYTES bytes via addressed auto-increment streams or broadcast. A commit command transfers the shadow bank to output_pin in a single cycle, so outputs never show a partially written pattern.

---
 rtl/matrix_loader_if.sv | 9 +
 rtl/matrix_loader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - RPi parallel write bus feeding the matrix loader
interface matrix_loader_if;
  logic [7:0] RPI_IO;
  logic       write_strobe;
  logic       cmd_sel;

  modport master (output RPI_IO, output write_strobe, output cmd_sel);
  modport slave  (input RPI_IO, input write_strobe, input cmd_sel);
endinterface

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - synchronised RPi byte loader with shadow bank and atomic commit
module matrix_loader #(
  parameter int NUM_BYTES   = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_COMMIT = 1'b0
) (
  input  logic                   clk_100mhz,
  input  logic                   rst,
  matrix_loader_if.slave         rpi,
  output logic [NUM_BYTES*8-1:0] output_pin,
  output logic                   pmod1_1,
  output logic                   err_flag,
  output logic [15:0]            write_count
);
  localparam int               IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [6:0]       NB       = 7'(NUM_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, BCAST} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0]      stb_sync;
  logic [SYNC_STAGES-1:0]      cmd_sync;
  logic [SYNC_STAGES-1:0][7:0] io_sync;
  logic                        stb_prev;
  logic                        stb_rise;
  logic                        cur_cmd;
  logic [7:0]                  cur_byte;
  logic                        start_ok;

  logic [IDX_W-1:0]            idx;
  logic [NUM_BYTES*8-1:0]      shadow;

  logic do_load_idx, do_wr_lane, do_bcast, do_commit;
  logic do_clr_shadow, do_clr_err, do_set_err;

  // Strobe chain and its history reset high so a strobe held through reset is ignored.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      stb_sync <= '1;
      cmd_sync <= '0;
      io_sync  <= '0;
      stb_prev <= 1'b1;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], rpi.write_strobe};
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], rpi.cmd_sel};
      io_sync  <= {io_sync[SYNC_STAGES-2:0], rpi.RPI_IO};
      stb_prev <= stb_sync[SYNC_STAGES-1];
    end
  end

  assign stb_rise = stb_sync[SYNC_STAGES-1] & ~stb_prev;
  assign cur_cmd  = cmd_sync[SYNC_STAGES-1];
  assign cur_byte = io_sync[SYNC_STAGES-1];
  assign start_ok = {1'b0, cur_byte[5:0]} < NB;

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stb_rise && cur_cmd) begin
      case (cur_byte[7:6])
        2'b00:   state_nxt = start_ok ? STREAM : IDLE;
        2'b01:   state_nxt = BCAST;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    do_load_idx   = 1'b0;
    do_wr_lane    = 1'b0;
    do_bcast      = 1'b0;
    do_commit     = 1'b0;
    do_clr_shadow = 1'b0;
    do_clr_err    = 1'b0;
    do_set_err    = 1'b0;
    if (stb_rise) begin
      if (cur_cmd) begin
        case (cur_byte[7:6])
          2'b00: begin
            do_load_idx = start_ok;
            do_set_err  = ~start_ok;
          end
          2'b10: do_commit = 1'b1;
          2'b11: begin
            do_clr_err    = cur_byte[0];
            do_clr_shadow = ~cur_byte[0];
          end
          default: ;
        endcase
      end else begin
        case (state)
          STREAM:  do_wr_lane = 1'b1;
          BCAST:   do_bcast   = 1'b1;
          default: do_set_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      shadow      <= '0;
      output_pin  <= '0;
      err_flag    <= 1'b0;
      write_count <= '0;
      pmod1_1     <= 1'b0;
    end else begin
      pmod1_1 <= stb_rise;
      if (stb_rise) begin
        write_count <= write_count + 16'd1;
      end
      if (do_load_idx) begin
        idx <= cur_byte[IDX_W-1:0];
      end
      if (do_wr_lane) begin
        shadow[{idx, 3'b000} +: 8] <= cur_byte;
        if (AUTO_COMMIT) begin
          output_pin[{idx, 3'b000} +: 8] <= cur_byte;
        end
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (do_bcast) begin
        shadow <= {NUM_BYTES{cur_byte}};
        if (AUTO_COMMIT) begin
          output_pin <= {NUM_BYTES{cur_byte}};
        end
      end
      if (do_clr_shadow) begin
        shadow <= '0;
      end
      if (do_commit) begin
        output_pin <= shadow;
      end
      if (do_set_err) begin
        err_flag <= 1'b1;
      end else if (do_clr_err) begin
        err_flag <= 1'b0;
      end
    end
  end
endmodule
